// File: rtl/scan_mux.sv
// Registered N-channel x W-bit multiplexer with a round-robin scanner over enabled channels.
// Manual mode is a registered N:1 select; scan mode emits one enabled channel per cycle.
module scan_mux #(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int SW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   en_mask,
    input  logic           hold,
    output logic [W-1:0]   out,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    output logic           wrap
);

    // Output stream is valid-only with no backpressure: out and out_ch are meaningful
    // exactly in cycles where out_valid=1; the consumer must accept every such cycle.

    if (N < 2 || N > 256) begin : g_bad_n
        $error("scan_mux: N must be in 2..256");
    end
    if (W < 1) begin : g_bad_w
        $error("scan_mux: W must be at least 1");
    end
    if ((2 ** SW) < N) begin : g_bad_sw
        $error("scan_mux: SW too narrow for N channels");
    end

    logic [SW-1:0] ptr;

    logic [W-1:0]  sel_data;
    logic          sel_en;
    logic [W-1:0]  ptr_data;
    logic          ptr_en;

    logic          any_en;
    logic [SW-1:0] lowest_idx;
    logic          found_above;
    logic [SW-1:0] above_idx;

    // Channel lookup by index; indices at or above N match nothing and read as disabled.
    always_comb begin
        sel_data = '0;
        sel_en   = 1'b0;
        ptr_data = '0;
        ptr_en   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (SW'(i) == sel) begin
                sel_data = in[i*W +: W];
                sel_en   = en_mask[i];
            end
            if (SW'(i) == ptr) begin
                ptr_data = in[i*W +: W];
                ptr_en   = en_mask[i];
            end
        end
    end

    // Single-cycle priority search: walking downward leaves the lowest match as the final value.
    always_comb begin
        any_en      = 1'b0;
        lowest_idx  = '0;
        found_above = 1'b0;
        above_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                any_en     = 1'b1;
                lowest_idx = SW'(i);
                if (SW'(i) > ptr) begin
                    found_above = 1'b1;
                    above_idx   = SW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (hold) begin
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (!mode) begin
            out       <= sel_en ? sel_data : '0;
            out_ch    <= sel;
            out_valid <= sel_en;
            wrap      <= 1'b0;
        end else if (!any_en) begin
            out       <= '0;
            out_ch    <= ptr;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            // A pointer left on a channel disabled mid-scan emits one invalid beat, then moves on.
            out       <= ptr_en ? ptr_data : '0;
            out_ch    <= ptr;
            out_valid <= ptr_en;
            wrap      <= !found_above;
            ptr       <= found_above ? above_idx : lowest_idx;
        end
    end

endmodule
